issue_unit_n: RTL and testbench

Parametrised N-wide in-order issue stage with an integrated shifting scoreboard. It sits between the issue queue and the functional units. Each cycle it examines the oldest `ISSUE_WIDTH` queue entries and resolves operands from immediates, the regfile or the bypass network. It issues the longest ready in-order prefix, handling intra-group RAW hazards and branch/delay-slot pairing, then registers the issued group into `fu_require`.

---
 rtl/issue_unit_n_pkg.sv | 58 +++++
 rtl/issue_unit_n_score_board_shift.sv | 64 ++++++
 rtl/issue_unit_n.sv | 189 ++++++++++++++++++
 tb/tb_issue_unit_n.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_unit_n_pkg.sv
// Shared types for the N-wide in-order issue stage and its shifting scoreboard.
// Widths are sized for the largest supported configuration: up to 8 issue
// slots and up to 8 bypassable pipe stages. Smaller configurations use the
// low bits of position/accept_mask.
package issue_unit_n_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned OP_W       = 4;
    localparam int unsigned POS_W      = 8;
    localparam int unsigned LINE_W     = 3;

    typedef logic                  bool;
    typedef logic [REG_W-1:0]      reg_width_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        EXE_ALU    = 2'd0,
        EXE_BRANCH = 2'd1,
        EXE_LSU    = 2'd2,
        EXE_MUL    = 2'd3
    } exe_type_e;

    typedef struct packed {
        exe_type_e        exe_type;
        logic [OP_W-1:0]  op;
        bool              num1_need;
        reg_addr_t        num1_addr;
        reg_width_t       num1;
        bool              num2_need;
        reg_addr_t        num2_addr;
        reg_width_t       num2;
        bool              write_reg_need;
        reg_addr_t        write_reg_addr;
        logic [POS_W-1:0] accept_mask;
    } issue_queue_element_t;

    typedef struct packed {
        exe_type_e       exe_type;
        logic [OP_W-1:0] op;
        reg_width_t      num1;
        reg_width_t      num2;
        bool             write_reg_need;
        reg_addr_t       write_reg_addr;
    } fu_require_t;

    typedef struct packed {
        logic [LINE_W-1:0] line;
        logic [POS_W-1:0]  position;
        logic [POS_W-1:0]  accept_mask;
    } score_board_data_t;

    // True when the element produces a real (non-r0) register result.
    function automatic logic dest_live(input issue_queue_element_t e);
        return e.write_reg_need && (e.write_reg_addr != '0);
    endfunction

endpackage

// File: rtl/issue_unit_n_score_board_shift.sv
// score_board_shift: per-register pipeline-position tracker.
// Ports: clk/rst (sync, active-high), hold (freeze all entries),
//        wr_en/wr_addr/wr_accept_mask per issue slot (higher slot wins on WAW),
//        rd_addr/rd_data per operand (combinational lookup of current state).
// Each entry's one-hot position shifts right every non-held cycle; r0 reads zero.
module score_board_shift
    import issue_unit_n_pkg::*;
#(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned PIPE_DEPTH  = 3,
    parameter int unsigned NUM_REGS    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              wr_en          [ISSUE_WIDTH],
    input  reg_addr_t         wr_addr        [ISSUE_WIDTH],
    input  logic [POS_W-1:0]  wr_accept_mask [ISSUE_WIDTH],
    input  reg_addr_t         rd_addr        [2*ISSUE_WIDTH],
    output score_board_data_t rd_data        [2*ISSUE_WIDTH]
);

    score_board_data_t entry_q [NUM_REGS];
    score_board_data_t entry_d [NUM_REGS];

    // Shift every entry, then apply this cycle's loads in slot order.
    always_comb begin
        entry_d = entry_q;
        if (!hold) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                entry_d[r].position = entry_q[r].position >> 1;
                if (entry_d[r].position == '0) begin
                    entry_d[r] = '0;
                end
            end
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                if (wr_en[i] && (wr_addr[i] != '0)) begin
                    entry_d[wr_addr[i]].line        = LINE_W'(i);
                    entry_d[wr_addr[i]].position    = POS_W'(1) << (PIPE_DEPTH - 1);
                    entry_d[wr_addr[i]].accept_mask = wr_accept_mask[i];
                end
            end
        end
        entry_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                entry_q[r] <= '0;
            end
        end else begin
            entry_q <= entry_d;
        end
    end

    // Operand lookup against the current (pre-shift) state.
    always_comb begin
        for (int unsigned k = 0; k < 2*ISSUE_WIDTH; k++) begin
            rd_data[k] = (rd_addr[k] == '0) ? '0 : entry_q[rd_addr[k]];
        end
    end

endmodule

// File: rtl/issue_unit_n.sv
// issue_unit_n: N-wide in-order issue stage.
// Ports: clk/rst (sync, active-high), flash (squash issue), stall (freeze stage),
//        issue_require/iq_size (queue head, slot 0 oldest), iq_pop_number (comb),
//        score_board_data (per-operand lookup to bypass mux), bypass_result,
//        regfile_read_ena/addr/data, fu_valid/fu_require (registered issued group).
// Issues the longest ready in-order prefix; a branch only issues with its delay slot.
module issue_unit_n
    import issue_unit_n_pkg::*;
#(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned PIPE_DEPTH  = 3,
    parameter int unsigned NUM_REGS    = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flash,
    input  logic                               stall,
    input  issue_queue_element_t               issue_require     [ISSUE_WIDTH],
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   iq_size,
    output logic [$clog2(ISSUE_WIDTH+1)-1:0]   iq_pop_number,
    output score_board_data_t                  score_board_data  [2*ISSUE_WIDTH],
    input  reg_width_t                         bypass_result     [2*ISSUE_WIDTH],
    output bool                                regfile_read_ena  [2*ISSUE_WIDTH],
    output reg_addr_t                          regfile_read_addr [2*ISSUE_WIDTH],
    input  reg_width_t                         regfile_read_data [2*ISSUE_WIDTH],
    output bool                                fu_valid          [ISSUE_WIDTH],
    output fu_require_t                        fu_require        [ISSUE_WIDTH]
);

    localparam int unsigned CNT_W = $clog2(ISSUE_WIDTH + 1);
    localparam int unsigned NOPS  = 2 * ISSUE_WIDTH;

    logic              op_need  [NOPS];
    reg_addr_t         op_addr  [NOPS];
    reg_width_t        op_imm   [NOPS];
    logic              op_raw   [NOPS];
    logic              op_ready [NOPS];
    reg_width_t        op_value [NOPS];
    score_board_data_t sb_rd_data [NOPS];

    logic              sb_wr_en   [ISSUE_WIDTH];
    reg_addr_t         sb_wr_addr [ISSUE_WIDTH];
    logic [POS_W-1:0]  sb_wr_mask [ISSUE_WIDTH];

    logic              cand  [ISSUE_WIDTH+1];
    logic              issue [ISSUE_WIDTH];
    logic              go;
    logic              ok;
    logic              in_delay;
    logic [CNT_W-1:0]  issue_cnt;

    logic              fu_valid_q   [ISSUE_WIDTH];
    logic              fu_valid_d   [ISSUE_WIDTH];
    fu_require_t       fu_require_q [ISSUE_WIDTH];
    fu_require_t       fu_require_d [ISSUE_WIDTH];

    score_board_shift #(
        .ISSUE_WIDTH (ISSUE_WIDTH),
        .PIPE_DEPTH  (PIPE_DEPTH),
        .NUM_REGS    (NUM_REGS)
    ) u_score_board (
        .clk            (clk),
        .rst            (rst),
        .hold           (stall),
        .wr_en          (sb_wr_en),
        .wr_addr        (sb_wr_addr),
        .wr_accept_mask (sb_wr_mask),
        .rd_addr        (op_addr),
        .rd_data        (sb_rd_data)
    );

    // Flatten operands: index 2i is num1 of slot i, 2i+1 is num2.
    always_comb begin
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            op_need[2*i]   = issue_require[i].num1_need;
            op_addr[2*i]   = issue_require[i].num1_addr;
            op_imm[2*i]    = issue_require[i].num1;
            op_need[2*i+1] = issue_require[i].num2_need;
            op_addr[2*i+1] = issue_require[i].num2_addr;
            op_imm[2*i+1]  = issue_require[i].num2;
        end
        for (int unsigned k = 0; k < NOPS; k++) begin
            regfile_read_ena[k]  = op_need[k];
            regfile_read_addr[k] = op_addr[k];
            score_board_data[k]  = sb_rd_data[k];
        end
    end

    // Operand readiness: immediate, intra-group RAW, regfile, then bypass.
    always_comb begin
        for (int unsigned k = 0; k < NOPS; k++) begin
            op_raw[k] = 1'b0;
            for (int unsigned j = 0; j < ISSUE_WIDTH; j++) begin
                if ((j < (k >> 1)) && dest_live(issue_require[j]) &&
                    (issue_require[j].write_reg_addr == op_addr[k])) begin
                    op_raw[k] = 1'b1;
                end
            end
            op_ready[k] = 1'b1;
            op_value[k] = op_imm[k];
            if (op_need[k]) begin
                if (op_raw[k]) begin
                    op_ready[k] = 1'b0;
                    op_value[k] = '0;
                end else if (sb_rd_data[k].position == '0) begin
                    op_value[k] = regfile_read_data[k];
                end else if ((sb_rd_data[k].position & sb_rd_data[k].accept_mask) != '0) begin
                    op_value[k] = bypass_result[k];
                end else begin
                    op_ready[k] = 1'b0;
                    op_value[k] = '0;
                end
            end
        end
    end

    // Longest in-order prefix; a branch needs its delay slot (next slot) ready too.
    always_comb begin
        go        = 1'b1;
        ok        = 1'b0;
        in_delay  = 1'b0;
        issue_cnt = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            cand[i] = (CNT_W'(i) < iq_size) && op_ready[2*i] && op_ready[2*i+1];
        end
        cand[ISSUE_WIDTH] = 1'b0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            ok = cand[i];
            if (!in_delay && (issue_require[i].exe_type == EXE_BRANCH)) begin
                ok = ok && cand[i+1];
            end
            go       = go && ok;
            issue[i] = go;
            in_delay = (issue_require[i].exe_type == EXE_BRANCH) && !in_delay;
            if (go) begin
                issue_cnt = issue_cnt + CNT_W'(1);
            end
        end
    end

    // Pop count, scoreboard loads and next issued group under stall/flash.
    always_comb begin
        fu_valid_d    = fu_valid_q;
        fu_require_d  = fu_require_q;
        iq_pop_number = '0;
        for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
            sb_wr_en[i]   = 1'b0;
            sb_wr_addr[i] = issue_require[i].write_reg_addr;
            sb_wr_mask[i] = issue_require[i].accept_mask;
        end
        if (!stall) begin
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                fu_valid_d[i]   = 1'b0;
                fu_require_d[i] = '0;
            end
            if (!flash) begin
                iq_pop_number = issue_cnt;
                for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                    if (issue[i]) begin
                        fu_valid_d[i]                  = 1'b1;
                        fu_require_d[i].exe_type       = issue_require[i].exe_type;
                        fu_require_d[i].op             = issue_require[i].op;
                        fu_require_d[i].num1           = op_value[2*i];
                        fu_require_d[i].num2           = op_value[2*i+1];
                        fu_require_d[i].write_reg_need = issue_require[i].write_reg_need;
                        fu_require_d[i].write_reg_addr = issue_require[i].write_reg_addr;
                        sb_wr_en[i]                    = issue_require[i].write_reg_need;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
                fu_valid_q[i]   <= 1'b0;
                fu_require_q[i] <= '0;
            end
        end else begin
            fu_valid_q   <= fu_valid_d;
            fu_require_q <= fu_require_d;
        end
    end

    assign fu_valid   = fu_valid_q;
    assign fu_require = fu_require_q;

endmodule

// File: tb/tb_issue_unit_n.sv
// Directed bench for issue_unit_n (W=2 and W=4 instances). Stimulus pushes the
// expected registered issue group per cycle; a monitor pops and compares it
// after each clock edge. Combinational outputs are checked inline.
module tb_issue_unit_n;
    import issue_unit_n_pkg::*;

    localparam logic [POS_W-1:0] M100 = POS_W'(4);
    localparam logic [POS_W-1:0] M010 = POS_W'(2);
    localparam logic [POS_W-1:0] M001 = POS_W'(1);
    localparam reg_width_t       BP0  = 32'hB000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flash, stall;

    issue_queue_element_t iq2 [2];
    logic [1:0]           iq2_size, pop2;
    score_board_data_t    sb2 [4];
    reg_width_t           bp2 [4], rfd2 [4];
    logic                 rfe2 [4];
    reg_addr_t            rfa2 [4];
    logic                 fv2 [2];
    fu_require_t          fr2 [2];

    issue_queue_element_t iq4 [4];
    logic [2:0]           iq4_size, pop4;
    score_board_data_t    sb4 [8];
    reg_width_t           bp4 [8], rfd4 [8];
    logic                 rfe4 [8];
    reg_addr_t            rfa4 [8];
    logic                 fv4 [4];
    fu_require_t          fr4 [4];

    issue_unit_n #(.ISSUE_WIDTH(2), .PIPE_DEPTH(3), .NUM_REGS(32)) dut2 (
        .clk(clk), .rst(rst), .flash(flash), .stall(stall),
        .issue_require(iq2), .iq_size(iq2_size), .iq_pop_number(pop2),
        .score_board_data(sb2), .bypass_result(bp2),
        .regfile_read_ena(rfe2), .regfile_read_addr(rfa2), .regfile_read_data(rfd2),
        .fu_valid(fv2), .fu_require(fr2)
    );

    issue_unit_n #(.ISSUE_WIDTH(4), .PIPE_DEPTH(3), .NUM_REGS(32)) dut4 (
        .clk(clk), .rst(rst), .flash(flash), .stall(stall),
        .issue_require(iq4), .iq_size(iq4_size), .iq_pop_number(pop4),
        .score_board_data(sb4), .bypass_result(bp4),
        .regfile_read_ena(rfe4), .regfile_read_addr(rfa4), .regfile_read_data(rfd4),
        .fu_valid(fv4), .fu_require(fr4)
    );

    function automatic reg_width_t rf(input int n);
        return 32'h100 + 32'(n);
    endfunction

    // Regfile holds 0x100+addr; bypass network presents 0xB000+operand index.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rfd2[k] = rf(int'(rfa2[k]));
            bp2[k]  = BP0 + 32'(k);
        end
        for (int k = 0; k < 8; k++) begin
            rfd4[k] = rf(int'(rfa4[k]));
            bp4[k]  = BP0 + 32'(k);
        end
    end

    typedef struct {
        string      tag;
        bit         sel4;
        logic [3:0] valid;
        reg_width_t v [4];
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input bit sel4, input logic [3:0] valid,
                        input reg_width_t a, input reg_width_t b,
                        input reg_width_t c, input reg_width_t d);
        exp_t e;
        e.tag = tag; e.sel4 = sel4; e.valid = valid;
        e.v[0] = a; e.v[1] = b; e.v[2] = c; e.v[3] = d;
        exp_q.push_back(e);
    endtask

    // Monitor: one expected issue group per clock edge.
    always @(posedge clk) begin
        exp_t       e;
        logic [3:0] act_v;
        reg_width_t act [4];
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (e.sel4) begin
                act_v  = {fv4[3], fv4[2], fv4[1], fv4[0]};
                act[0] = fr4[0].num1; act[1] = fr4[0].num2;
                act[2] = fr4[1].num1; act[3] = fr4[1].num2;
            end else begin
                act_v  = {2'b00, fv2[1], fv2[0]};
                act[0] = fr2[0].num1; act[1] = fr2[0].num2;
                act[2] = fr2[1].num1; act[3] = fr2[1].num2;
            end
            chk({e.tag, "_fu_valid"}, 32'(act_v), 32'(e.valid));
            for (int s = 0; s < 4; s++) begin
                chk($sformatf("%s_fu_num%0d", e.tag, s), act[s], e.v[s]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic issue_queue_element_t alu(input int d, input int a, input int b,
                                                 input logic [POS_W-1:0] m);
        issue_queue_element_t e;
        e = '0;
        e.exe_type       = EXE_ALU;
        e.op             = 4'h1;
        e.num1_need      = 1'b1;
        e.num1_addr      = reg_addr_t'(a);
        e.num2_need      = 1'b1;
        e.num2_addr      = reg_addr_t'(b);
        e.write_reg_need = 1'b1;
        e.write_reg_addr = reg_addr_t'(d);
        e.accept_mask    = m;
        return e;
    endfunction

    function automatic issue_queue_element_t br();
        issue_queue_element_t e;
        e = alu(0, 1, 2, M001);
        e.exe_type       = EXE_BRANCH;
        e.write_reg_need = 1'b0;
        return e;
    endfunction

    initial begin
        rst = 1'b1; flash = 1'b0; stall = 1'b0;
        iq2_size = '0; iq4_size = '0;
        for (int i = 0; i < 2; i++) iq2[i] = '0;
        for (int i = 0; i < 4; i++) iq4[i] = '0;

        // Reset: registered outputs cleared.
        #1; push("reset0", 0, 4'b0000, 0, 0, 0, 0); @(negedge clk);
        #1; push("reset1", 1, 4'b0000, 0, 0, 0, 0); @(negedge clk);
        rst = 1'b0;

        // A: independent ops issue together with regfile values.
        iq2[0] = alu(3, 1, 2, M100); iq2[1] = alu(4, 5, 6, M100); iq2_size = 2;
        #1; chk("A_pop", 32'(pop2), 2);
        push("A", 0, 4'b0011, rf(1), rf(2), rf(5), rf(6)); @(negedge clk);

        // B: intra-group RAW on r3 holds slot 1.
        iq2[0] = alu(3, 1, 2, M100); iq2[1] = alu(7, 3, 1, M100);
        #1; chk("B_pop", 32'(pop2), 1);
        push("B", 0, 4'b0001, rf(1), rf(2), 0, 0); @(negedge clk);

        // C: r3 at EX with mask 100 -> bypass.
        iq2[0] = alu(7, 3, 1, M100); iq2[1] = alu(8, 10, 11, M100);
        #1; chk("C_sb_pos", 32'(sb2[0].position), 32'(M100));
        chk("C_sb_line", 32'(sb2[0].line), 0);
        chk("C_pop", 32'(pop2), 2);
        push("C", 0, 4'b0011, BP0, rf(1), rf(10), rf(11)); @(negedge clk);

        // D: producer r12 with accept_mask 001.
        iq2[0] = alu(12, 1, 2, M001); iq2[1] = alu(13, 1, 2, M100);
        #1; chk("D_pop", 32'(pop2), 2);
        push("D", 0, 4'b0011, rf(1), rf(2), rf(1), rf(2)); @(negedge clk);

        // E/F/G: consumer of r12 waits until position reaches 001.
        iq2[0] = alu(14, 12, 0, M100); iq2[0].num2_need = 1'b0; iq2[0].num2 = 32'd5;
        iq2[1] = alu(15, 1, 2, M100);
        #1; chk("E_sb_pos", 32'(sb2[0].position), 32'(M100));
        chk("E_sb_mask", 32'(sb2[0].accept_mask), 32'(M001));
        chk("E_pop", 32'(pop2), 0);
        push("E", 0, 4'b0000, 0, 0, 0, 0); @(negedge clk);
        #1; chk("F_sb_pos", 32'(sb2[0].position), 32'(M010));
        chk("F_pop", 32'(pop2), 0);
        push("F", 0, 4'b0000, 0, 0, 0, 0); @(negedge clk);
        #1; chk("G_pop", 32'(pop2), 2);
        push("G", 0, 4'b0011, BP0, 32'd5, rf(1), rf(2)); @(negedge clk);

        // H: branch in last slot holds; I: branch+delay slot pair.
        iq2[0] = alu(16, 1, 2, M100); iq2[1] = br();
        #1; chk("H_pop", 32'(pop2), 1);
        push("H", 0, 4'b0001, rf(1), rf(2), 0, 0); @(negedge clk);
        iq2[0] = br(); iq2[1] = alu(17, 1, 2, M100);
        #1; chk("I_pop", 32'(pop2), 2);
        push("I", 0, 4'b0011, rf(1), rf(2), rf(1), rf(2)); @(negedge clk);

        // J: branch without delay slot present.
        iq2_size = 1;
        #1; chk("J_pop", 32'(pop2), 0);
        push("J", 0, 4'b0000, 0, 0, 0, 0); @(negedge clk);

        // K: flash squashes two ready ops.
        flash = 1'b1; iq2[0] = alu(20, 1, 2, M100); iq2[1] = alu(21, 1, 2, M100); iq2_size = 2;
        #1; chk("K_pop", 32'(pop2), 0);
        push("K", 0, 4'b0000, 0, 0, 0, 0); @(negedge clk);

        // L: r20 never loaded; r17 kept shifting to 001.
        flash = 1'b0; iq2[0] = alu(29, 20, 17, M100); iq2_size = 0;
        #1; chk("L_sb_r20", 32'(sb2[0].position), 0);
        chk("L_sb_r17", 32'(sb2[1].position), 32'(M001));
        chk("L_rf_ena", 32'(rfe2[0]), 1);
        chk("L_rf_addr", 32'(rfa2[1]), 17);
        chk("L_pop", 32'(pop2), 0);
        push("L", 0, 4'b0000, 0, 0, 0, 0); @(negedge clk);

        // M/N: r5 produced then consumed via bypass.
        iq2[0] = alu(5, 1, 2, M100); iq2[1] = alu(22, 1, 2, M100); iq2_size = 2;
        #1; chk("M_pop", 32'(pop2), 2);
        push("M", 0, 4'b0011, rf(1), rf(2), rf(1), rf(2)); @(negedge clk);
        iq2[0] = alu(25, 5, 2, M100); iq2[1] = alu(26, 1, 2, M100);
        #1; chk("N_sb_pos", 32'(sb2[0].position), 32'(M100));
        chk("N_pop", 32'(pop2), 2);
        push("N", 0, 4'b0011, BP0, rf(2), rf(1), rf(2)); @(negedge clk);

        // O: stall 3 cycles, r5 frozen at 010 and fu holds.
        stall = 1'b1; iq2[0] = alu(27, 5, 1, M100); iq2[1] = alu(28, 1, 2, M100);
        for (int c = 0; c < 3; c++) begin
            #1; chk($sformatf("O%0d_pop", c), 32'(pop2), 0);
            chk($sformatf("O%0d_sb_pos", c), 32'(sb2[0].position), 32'(M010));
            push($sformatf("O%0d", c), 0, 4'b0011, BP0, rf(2), rf(1), rf(2));
            @(negedge clk);
        end

        // P/Q: after release the entry resumes shifting.
        stall = 1'b0; iq2_size = 0;
        #1; chk("P_sb_pos", 32'(sb2[0].position), 32'(M010));
        push("P", 0, 4'b0000, 0, 0, 0, 0); @(negedge clk);
        #1; chk("Q_sb_pos", 32'(sb2[0].position), 32'(M001));
        push("Q", 0, 4'b0000, 0, 0, 0, 0); @(negedge clk);

        // R: W=4, r0 write and WAW on r9 from slots 1 and 3.
        iq4[0] = alu(0, 1, 2, M100); iq4[1] = alu(9, 1, 2, M100);
        iq4[2] = alu(10, 1, 2, M100); iq4[3] = alu(9, 1, 2, M001); iq4_size = 4;
        #1; chk("R_pop", 32'(pop4), 4);
        push("R", 1, 4'b1111, rf(1), rf(2), rf(1), rf(2)); @(negedge clk);

        // S: r9 entry owned by slot 3; r0 always at position 0.
        iq4[0] = alu(30, 9, 0, M100); iq4_size = 0;
        #1; chk("S_sb_line", 32'(sb4[0].line), 3);
        chk("S_sb_pos", 32'(sb4[0].position), 32'(M100));
        chk("S_sb_mask", 32'(sb4[0].accept_mask), 32'(M001));
        chk("S_sb_r0", 32'(sb4[1].position), 0);
        push("S", 1, 4'b0000, 0, 0, 0, 0); @(negedge clk);

        // T: W=4 RAW at slot 3 on slot 1 -> three issue.
        iq4[0] = alu(11, 1, 2, M100); iq4[1] = alu(12, 1, 2, M100);
        iq4[2] = alu(13, 1, 2, M100); iq4[3] = alu(14, 12, 1, M100); iq4_size = 4;
        #1; chk("T_pop", 32'(pop4), 3);
        push("T", 1, 4'b0111, rf(1), rf(2), rf(1), rf(2)); @(negedge clk);

        // U/V: reset mid-stream clears fu and scoreboard.
        rst = 1'b1;
        #1; push("U", 1, 4'b0000, 0, 0, 0, 0); @(negedge clk);
        rst = 1'b0; iq4[0] = alu(31, 11, 9, M100); iq4_size = 0;
        #1; chk("V_sb_r11", 32'(sb4[0].position), 0);
        chk("V_sb_r9", 32'(sb4[1].position), 0);
        push("V", 1, 4'b0000, 0, 0, 0, 0); @(negedge clk);

        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
